// File: rtl/alu_seq_ctrl.sv
// Single-issue sequencer: reads two reg_bank sources, runs one ALU op through a
// start/done handshake and optionally writes the result back. All outputs registered.
module alu_seq_ctrl #(
  parameter int DW      = 64,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_opr,
  input  logic [3:0]    instr_rsA,
  input  logic [3:0]    instr_rsB,
  input  logic [3:0]    instr_rd,
  input  logic          instr_wb,
  output logic          instr_done,
  output logic          instr_err,
  output logic          busy,
  output logic [CW-1:0] op_count,
  output logic          regwen,
  output logic [3:0]    selwreg,
  output logic [1:0]    endwreg,
  output logic [DW-1:0] wdata,
  output logic [3:0]    seloutA,
  output logic [3:0]    seloutB,
  output logic          enrregA,
  output logic          enrregB,
  output logic          cnstA,
  output logic          cnstB,
  output logic [3:0]    alu_opr,
  output logic          alu_start,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_START, S_WAIT, S_WB, S_FIN, S_ERR
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [15:0] tmo_cnt;
  logic [3:0]  rd_q;
  logic        wb_q;
  logic        accept, done_ev, tmo_hit, hold_src;

  assign accept   = instr_valid & instr_ready;
  assign done_ev  = (state == S_WAIT) & alu_done;
  assign tmo_hit  = (state == S_WAIT) & ~alu_done & (tmo_cnt == TMO_LAST);
  assign hold_src = (state_nx == S_START) | (state_nx == S_WAIT);

  assign endwreg = 2'b00;
  assign cnstA   = 1'b0;
  assign cnstB   = 1'b0;

  always_comb begin
    state_nx = state;
    case (state)
      // Terminal states also accept, so a new op can enter RD on the edge leaving them.
      S_IDLE, S_WB, S_FIN, S_ERR: state_nx = accept ? S_RD : S_IDLE;
      S_RD:    state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (done_ev)      state_nx = wb_q ? S_WB : S_FIN;
        else if (tmo_hit) state_nx = S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_START)     tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
      if (accept) begin
        rd_q <= instr_rd;
        wb_q <= instr_wb;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_ready <= 1'b0;
      instr_done  <= 1'b0;
      instr_err   <= 1'b0;
      busy        <= 1'b0;
      op_count    <= '0;
      regwen      <= 1'b0;
      selwreg     <= '0;
      wdata       <= '0;
      seloutA     <= '0;
      seloutB     <= '0;
      enrregA     <= 1'b0;
      enrregB     <= 1'b0;
      alu_opr     <= '0;
      alu_start   <= 1'b0;
    end else begin
      instr_ready <= (state_nx == S_IDLE) | (state_nx == S_WB) |
                     (state_nx == S_FIN)  | (state_nx == S_ERR);
      busy        <= (state_nx != S_IDLE);
      instr_done  <= (state_nx == S_WB) | (state_nx == S_FIN);
      instr_err   <= (state_nx == S_ERR);
      if ((state_nx == S_WB) | (state_nx == S_FIN))
        op_count <= op_count + CW'(1);
      regwen      <= (state_nx == S_WB);
      selwreg     <= (state_nx == S_WB) ? rd_q : 4'd0;
      wdata       <= done_ev ? alu_result : '0;
      // Source selects come straight from the instruction on the accepting edge, then hold.
      seloutA     <= (state_nx == S_RD) ? instr_rsA : (hold_src ? seloutA : 4'd0);
      seloutB     <= (state_nx == S_RD) ? instr_rsB : (hold_src ? seloutB : 4'd0);
      alu_opr     <= (state_nx == S_RD) ? instr_opr : (hold_src ? alu_opr : 4'd0);
      enrregA     <= (state_nx == S_RD);
      enrregB     <= (state_nx == S_RD);
      alu_start   <= (state_nx == S_START);
    end
  end

endmodule
